// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, exception/ERET redirect sequencing, stall counter and watchdog
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E,
  parameter int          WDOG_LIMIT = 4096,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             redirect_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             wdog_err
);

  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_LIMIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_redir_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [WD_W-1:0]  r_wdog_cnt;
  logic             r_wdog_err;

  logic             w_exc_take;
  logic [31:0]      w_exc_pc;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic [31:0]      w_new_pc;
  logic             w_redirect_valid;

  // An exception waits for a quiet MEM stage so the faulting access has settled
  assign w_exc_take = (r_state == ST_RUN) && (excepttype_i != 32'd0) && !stallreq_from_mem;
  assign w_exc_pc   = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

  // Combinational stall/flush/redirect outputs; everything is held at zero during reset
  always_comb begin
    w_stall          = 6'b000000;
    w_flush          = 1'b0;
    w_new_pc         = 32'd0;
    w_redirect_valid = 1'b0;
    if (!rst) begin
      if (r_state == ST_REDIRECT) begin
        // Downstream stages were flushed, so only IF can hold the redirect
        w_stall          = {4'b0000, stallreq_from_if, stallreq_from_if};
        w_new_pc         = r_redir_pc;
        w_redirect_valid = 1'b1;
      end else if (w_exc_take) begin
        w_flush          = 1'b1;
        w_new_pc         = w_exc_pc;
        w_redirect_valid = 1'b1;
      end else if (stallreq_from_mem) begin
        w_stall = 6'b011111;
      end else if (stallreq_from_ex) begin
        w_stall = 6'b001111;
      end else if (stallreq_from_id) begin
        w_stall = 6'b000111;
      end else if (stallreq_from_if) begin
        w_stall = 6'b000011;
      end
    end
  end

  assign stall          = w_stall;
  assign flush          = w_flush;
  assign new_pc         = w_new_pc;
  assign redirect_valid = w_redirect_valid;
  assign stall_cnt      = r_stall_cnt;
  assign wdog_err       = r_wdog_err;

  // Redirect FSM plus stall-cycle counter and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_redir_pc  <= 32'd0;
      r_stall_cnt <= '0;
      r_wdog_cnt  <= '0;
      r_wdog_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc_take) begin
            r_redir_pc <= w_exc_pc;
            r_state    <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (!stallreq_from_if) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      if (w_stall != 6'b000000) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      if (w_stall[0]) begin
        if (r_wdog_cnt != WD_MAX) begin
          r_wdog_cnt <= r_wdog_cnt + WD_W'(1);
        end
        if (r_wdog_cnt == WD_LAST) begin
          r_wdog_err <= 1'b1;
        end
      end else begin
        r_wdog_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed vectors
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        rv;
  logic [31:0] stall_cnt;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int          tag;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        rv;
    bit          chk_cnt;
    logic [31:0] cnt;
    logic        wd;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(
    .EXC_VECTOR(32'hBFC00380),
    .ERET_CODE (32'h0000000E),
    .WDOG_LIMIT(8),
    .CNT_W     (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (req_if),
    .stallreq_from_id (req_id),
    .stallreq_from_ex (req_ex),
    .stallreq_from_mem(req_mem),
    .excepttype_i     (exc),
    .cp0_epc_i        (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .redirect_valid   (rv),
    .stall_cnt        (stall_cnt),
    .wdog_err         (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", tag, nm, act, exp_v);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "stall", {26'd0, stall}, {26'd0, e.st});
      chk(e.tag, "flush", {31'd0, flush}, {31'd0, e.fl});
      chk(e.tag, "new_pc", new_pc, e.pc);
      chk(e.tag, "redirect_valid", {31'd0, rv}, {31'd0, e.rv});
      chk(e.tag, "wdog_err", {31'd0, wdog_err}, {31'd0, e.wd});
      if (e.chk_cnt) chk(e.tag, "stall_cnt", stall_cnt, e.cnt);
    end
  end

  // req = {mem, ex, id, if}
  task automatic step(input logic r, input logic [3:0] req, input logic [31:0] ex_t,
                      input logic [31:0] ep_v, input logic [5:0] es, input logic ef,
                      input logic [31:0] epc_exp, input logic erv, input bit cc,
                      input logic [31:0] ec, input logic ew);
    exp_t e;
    rst     = r;
    req_mem = req[3];
    req_ex  = req[2];
    req_id  = req[1];
    req_if  = req[0];
    exc     = ex_t;
    epc     = ep_v;
    step_no++;
    e.tag = step_no; e.st = es; e.fl = ef; e.pc = epc_exp; e.rv = erv;
    e.chk_cnt = cc; e.cnt = ec; e.wd = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [31:0] EPC = 32'h80001234;

  initial begin
    rst = 1'b1; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0; exc = 0; epc = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state and stall counter
    step(1, 4'b1111, 0, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
    step(0, 4'b1111, 0, 0, 6'b011111, 0, 0, 0, 1, 0, 0);
    step(0, 4'b1111, 0, 0, 6'b011111, 0, 0, 0, 1, 1, 0);
    step(0, 4'b1111, 0, 0, 6'b011111, 0, 0, 0, 1, 2, 0);
    step(1, 4'b1111, 0, 0, 6'b000000, 0, 0, 0, 1, 3, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
    // Priority sweep
    step(0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0, 1, 0, 0);
    step(0, 4'b0011, 0, 0, 6'b000111, 0, 0, 0, 1, 1, 0);
    step(0, 4'b0110, 0, 0, 6'b001111, 0, 0, 0, 1, 2, 0);
    step(0, 4'b1100, 0, 0, 6'b011111, 0, 0, 0, 1, 3, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 4, 0);
    // Exception, IF ready: one flush cycle, one REDIRECT cycle ignoring ID/EX/exc
    step(0, 4'b0000, 32'h1, 0, 6'b000000, 1, VEC, 1, 1, 4, 0);
    step(0, 4'b0110, 32'h1, 0, 6'b000000, 0, VEC, 1, 1, 4, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 4, 0);
    // ERET with IF busy 3 cycles; EPC change during redirect must not leak
    step(0, 4'b0000, 32'hE, EPC, 6'b000000, 1, EPC, 1, 0, 0, 0);
    step(0, 4'b0001, 0, EPC, 6'b000011, 0, EPC, 1, 0, 0, 0);
    step(0, 4'b0001, 0, 32'h12345678, 6'b000011, 0, EPC, 1, 0, 0, 0);
    step(0, 4'b0001, 0, 0, 6'b000011, 0, EPC, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, EPC, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 7, 0);
    // Exception deferred by MEM stall
    step(0, 4'b1000, 32'h4, 0, 6'b011111, 0, 0, 0, 0, 0, 0);
    step(0, 4'b1000, 32'h4, 0, 6'b011111, 0, 0, 0, 0, 0, 0);
    step(0, 4'b0000, 32'h4, 0, 6'b000000, 1, VEC, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, VEC, 1, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 9, 0);
    // Watchdog: 7 stall[0] cycles is not enough, the 8th sets the sticky error
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0, 0, 0, 0);
    end
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 17, 1);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 1);
    step(1, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 1);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
    // Reset while in REDIRECT: back to RUN with no further redirect
    step(0, 4'b0000, 32'h1, 0, 6'b000000, 1, VEC, 1, 0, 0, 0);
    step(1, 4'b0001, 0, 0, 6'b000000, 0, 0, 0, 1, 0, 0);
    step(0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0, 1, 0, 0);
    step(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0, 1, 1, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
